// File: rtl/graphics_pipeline_sequencer_pkg.sv
// graphics_pipeline_sequencer_pkg: shared state encoding, parameter map and sizes
package graphics_pipeline_sequencer_pkg;
  localparam int param_w = 16;
  localparam int param_n = 16;
  typedef enum logic [1:0] {st_idle, st_issue, st_wait, st_output} state_t;
  localparam logic [4:0] a_cam_ver_x = 5'd0;
  localparam logic [4:0] a_cam_ver_y = 5'd1;
  localparam logic [4:0] a_cam_ver_z = 5'd2;
  localparam logic [4:0] a_cam_dc = 5'd3;
  localparam logic [4:0] a_cos_roll = 5'd4;
  localparam logic [4:0] a_cos_pitch = 5'd5;
  localparam logic [4:0] a_cos_yaw = 5'd6;
  localparam logic [4:0] a_sen_roll = 5'd7;
  localparam logic [4:0] a_sen_pitch = 5'd8;
  localparam logic [4:0] a_sen_yaw = 5'd9;
  localparam logic [4:0] a_scale_x = 5'd10;
  localparam logic [4:0] a_scale_y = 5'd11;
  localparam logic [4:0] a_scale_z = 5'd12;
  localparam logic [4:0] a_transl_x = 5'd13;
  localparam logic [4:0] a_transl_y = 5'd14;
  localparam logic [4:0] a_transl_z = 5'd15;
endpackage

// File: rtl/graphics_pipeline_sequencer_param_regfile.sv
// gp_param_regfile: transform parameter registers with idle-only write and reject pulse
module gp_param_regfile
  import graphics_pipeline_sequencer_pkg::*;
#(
  parameter int N = param_n
)(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_en,
  input  logic [4:0]             addr,
  input  logic [param_w-1:0]     data,
  input  logic                   idle,
  output logic [N*param_w-1:0]   param_bus,
  output logic                   cfg_err
);
  localparam int aw = $clog2(N);
  logic [param_w-1:0] regs [N];
  logic ok;
  assign ok = wr_en && idle && (addr < 5'(N));
  for (genvar k = 0; k < N; k++) assign param_bus[k*param_w +: param_w] = regs[k];
  always_ff @(posedge clk)
    if (!rst_n) begin
      for (int i = 0; i < N; i++) regs[i] <= '0;
      cfg_err <= 1'b0;
    end else begin
      if (ok) regs[addr[aw-1:0]] <= data;
      cfg_err <= wr_en && !ok;
    end
endmodule

// File: rtl/graphics_pipeline_sequencer.sv
// graphics_pipeline_sequencer: batch sequencer feeding vertices to a fixed-latency transform datapath
module graphics_pipeline_sequencer
  import graphics_pipeline_sequencer_pkg::*;
#(
  parameter int LATENCY = 4,
  parameter int NUM_PARAMS = param_n
)(
  input  logic                          i_Clk,
  input  logic                          i_Rst_n,
  input  logic                          i_CfgWrEn,
  input  logic [4:0]                    i_CfgAddr,
  input  logic [param_w-1:0]            i_CfgData,
  output logic                          o_CfgErr,
  input  logic                          i_Start,
  input  logic [15:0]                   i_VertexCount,
  input  logic                          i_VertexValid,
  output logic                          o_VertexReady,
  input  logic [15:0]                   i_VertexX,
  input  logic [15:0]                   i_VertexY,
  input  logic [15:0]                   i_VertexZ,
  output logic [NUM_PARAMS*param_w-1:0] o_ParamBus,
  output logic [15:0]                   o_DpVertexX,
  output logic [15:0]                   o_DpVertexY,
  output logic [15:0]                   o_DpVertexZ,
  output logic                          o_DpValid,
  input  logic [15:0]                   i_DpResultX,
  input  logic [15:0]                   i_DpResultY,
  output logic                          o_PixelValid,
  input  logic                          i_PixelReady,
  output logic [15:0]                   o_PixelX,
  output logic [15:0]                   o_PixelY,
  output logic                          o_Busy,
  output logic                          o_Done
);
  state_t state;
  logic [15:0] remaining;
  logic [3:0] wait_cnt;
  assign o_VertexReady = state == st_issue;
  assign o_PixelValid = state == st_output;
  assign o_Busy = state != st_idle;
  gp_param_regfile #(.N(NUM_PARAMS)) u_regs (
    .clk(i_Clk),
    .rst_n(i_Rst_n),
    .wr_en(i_CfgWrEn),
    .addr(i_CfgAddr),
    .data(i_CfgData),
    .idle(state == st_idle),
    .param_bus(o_ParamBus),
    .cfg_err(o_CfgErr)
  );
  always_ff @(posedge i_Clk)
    if (!i_Rst_n) begin
      state <= st_idle;
      remaining <= '0;
      wait_cnt <= '0;
      o_DpVertexX <= '0;
      o_DpVertexY <= '0;
      o_DpVertexZ <= '0;
      o_DpValid <= 1'b0;
      o_PixelX <= '0;
      o_PixelY <= '0;
      o_Done <= 1'b0;
    end else begin
      o_DpValid <= 1'b0;
      o_Done <= 1'b0;
      case (state)
        st_idle:
          if (i_Start) begin
            if (i_VertexCount == '0) o_Done <= 1'b1;
            else begin
              remaining <= i_VertexCount;
              state <= st_issue;
            end
          end
        st_issue:
          if (i_VertexValid) begin
            o_DpVertexX <= i_VertexX;
            o_DpVertexY <= i_VertexY;
            o_DpVertexZ <= i_VertexZ;
            o_DpValid <= 1'b1;
            wait_cnt <= 4'(LATENCY);
            state <= st_wait;
          end
        st_wait: begin
          wait_cnt <= wait_cnt - 4'd1;
          if (wait_cnt == 4'd1) begin
            o_PixelX <= i_DpResultX;
            o_PixelY <= i_DpResultY;
            state <= st_output;
          end
        end
        st_output:
          if (i_PixelReady) begin
            remaining <= remaining - 16'd1;
            o_Done <= remaining == 16'd1;
            state <= remaining == 16'd1 ? st_idle : st_issue;
          end
        default: state <= st_idle;
      endcase
    end
endmodule

// File: tb/tb_graphics_pipeline_sequencer.sv
// tb_graphics_pipeline_sequencer: directed bench with a transaction-level reference model
module tb_graphics_pipeline_sequencer;
  import graphics_pipeline_sequencer_pkg::*;
  localparam int lat = 4;
  logic i_Clk = 1'b0;
  logic i_Rst_n, i_CfgWrEn, i_Start, i_VertexValid, i_PixelReady;
  logic [4:0] i_CfgAddr;
  logic [15:0] i_CfgData, i_VertexCount, i_VertexX, i_VertexY, i_VertexZ, i_DpResultX, i_DpResultY;
  logic o_CfgErr, o_VertexReady, o_DpValid, o_PixelValid, o_Busy, o_Done;
  logic [255:0] o_ParamBus;
  logic [15:0] o_DpVertexX, o_DpVertexY, o_DpVertexZ, o_PixelX, o_PixelY;
  graphics_pipeline_sequencer #(.LATENCY(lat), .NUM_PARAMS(16)) dut (
    .i_Clk(i_Clk), .i_Rst_n(i_Rst_n), .i_CfgWrEn(i_CfgWrEn), .i_CfgAddr(i_CfgAddr),
    .i_CfgData(i_CfgData), .o_CfgErr(o_CfgErr), .i_Start(i_Start), .i_VertexCount(i_VertexCount),
    .i_VertexValid(i_VertexValid), .o_VertexReady(o_VertexReady), .i_VertexX(i_VertexX),
    .i_VertexY(i_VertexY), .i_VertexZ(i_VertexZ), .o_ParamBus(o_ParamBus),
    .o_DpVertexX(o_DpVertexX), .o_DpVertexY(o_DpVertexY), .o_DpVertexZ(o_DpVertexZ),
    .o_DpValid(o_DpValid), .i_DpResultX(i_DpResultX), .i_DpResultY(i_DpResultY),
    .o_PixelValid(o_PixelValid), .i_PixelReady(i_PixelReady), .o_PixelX(o_PixelX),
    .o_PixelY(o_PixelY), .o_Busy(o_Busy), .o_Done(o_Done)
  );
  always #5 i_Clk = ~i_Clk;
  int n_cmp = 0, n_bad = 0, cyc = 0;
  logic [15:0] m_par [16] = '{default: '0};
  logic m_busy = 1'b0, m_pend = 1'b0;
  int m_rem = 0, m_due = -1, m_acc = -10, m_done = -10, m_err = -10;
  logic [15:0] m_vx = '0, m_vy = '0, m_vz = '0, m_px = '0, m_py = '0;
  logic [15:0] tb_rx = '0, tb_ry = '0, dp_rx = '0, dp_ry = '0;
  int dp_due = -1;
  int ev_acc = -1, ev_dpv = -1, ev_pv = -1, ev_hs = -1, ev_done = -1, n_pix = 0, n_done = 0, n_err = 0;
  logic prev_pv = 1'b0;
  logic [255:0] bus;
  logic rdy, acc, cap, hs;
  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  always @(negedge i_Clk) begin
    cyc++;
    i_DpResultX = dp_rx + 16'(cyc - dp_due);
    i_DpResultY = dp_ry + 16'(cyc - dp_due);
    bus = '0;
    for (int k = 0; k < 16; k++) bus[k*16 +: 16] = m_par[k];
    chk("parambus", o_ParamBus, bus);
    chk("busy", 256'(o_Busy), 256'(m_busy));
    chk("vready", 256'(o_VertexReady), 256'(m_busy && m_due < 0 && !m_pend));
    chk("dpvalid", 256'(o_DpValid), 256'(cyc == m_acc + 1));
    chk("dpvertex", 256'({o_DpVertexX, o_DpVertexY, o_DpVertexZ}), 256'({m_vx, m_vy, m_vz}));
    chk("pixvalid", 256'(o_PixelValid), 256'(m_pend));
    chk("pixel", 256'({o_PixelX, o_PixelY}), 256'({m_px, m_py}));
    chk("done", 256'(o_Done), 256'(cyc == m_done));
    chk("cfgerr", 256'(o_CfgErr), 256'(cyc == m_err));
    if (o_VertexReady && i_VertexValid) begin
      ev_acc = cyc;
      dp_due = cyc + lat;
      dp_rx = tb_rx;
      dp_ry = tb_ry;
    end
    if (o_DpValid) ev_dpv = cyc;
    if (o_PixelValid && !prev_pv) ev_pv = cyc;
    if (o_PixelValid && i_PixelReady) begin ev_hs = cyc; n_pix++; end
    if (o_Done) begin ev_done = cyc; n_done++; end
    if (o_CfgErr) n_err++;
    prev_pv = o_PixelValid;
    rdy = m_busy && m_due < 0 && !m_pend;
    acc = rdy && i_VertexValid;
    cap = cyc == m_due;
    hs = m_pend && i_PixelReady;
    if (!i_Rst_n) begin
      for (int k = 0; k < 16; k++) m_par[k] = '0;
      m_busy = 1'b0; m_pend = 1'b0; m_rem = 0; m_due = -1;
      m_acc = -10; m_done = -10; m_err = -10;
      m_vx = '0; m_vy = '0; m_vz = '0; m_px = '0; m_py = '0;
      dp_due = -1;
    end else begin
      if (i_CfgWrEn) begin
        if (!m_busy && i_CfgAddr < 5'd16) m_par[i_CfgAddr[3:0]] = i_CfgData;
        else m_err = cyc + 1;
      end
      if (i_Start && !m_busy) begin
        if (i_VertexCount == 16'd0) m_done = cyc + 1;
        else begin m_busy = 1'b1; m_rem = int'(i_VertexCount); end
      end
      if (acc) begin
        m_vx = i_VertexX; m_vy = i_VertexY; m_vz = i_VertexZ;
        m_acc = cyc; m_due = cyc + lat;
      end
      if (cap) begin
        m_pend = 1'b1; m_px = i_DpResultX; m_py = i_DpResultY; m_due = -1;
      end
      if (hs) begin
        m_pend = 1'b0;
        m_rem--;
        if (m_rem == 0) begin m_busy = 1'b0; m_done = cyc + 1; end
      end
    end
  end
  task automatic step();
    @(posedge i_Clk);
    #1;
  endtask
  task automatic cfg(input logic [4:0] a, input logic [15:0] d);
    i_CfgWrEn = 1'b1; i_CfgAddr = a; i_CfgData = d;
    step();
    i_CfgWrEn = 1'b0;
  endtask
  task automatic await(input bit want_pix, input string name);
    logic ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge i_Clk);
      ok = want_pix ? o_PixelValid : o_VertexReady;
    end
    chk(name, 256'(ok), 256'(1));
  endtask
  task automatic batch(input int n, input int hold_idx, input int hold, input logic [15:0] bx, by, bz);
    i_Start = 1'b1; i_VertexCount = 16'(n);
    step();
    i_Start = 1'b0; i_CfgWrEn = 1'b0;
    for (int v = 0; v < n; v++) begin
      i_VertexX = bx + 16'(v * 257); i_VertexY = by + 16'(v * 257); i_VertexZ = bz + 16'(v * 257);
      tb_rx = 16'h1234 + 16'(v * 16'h1111); tb_ry = 16'h5678 + 16'(v * 16'h1111);
      i_VertexValid = 1'b1;
      await(1'b0, "vready_timeout");
      step();
      i_VertexValid = 1'b0;
      await(1'b1, "pixvalid_timeout");
      step();
      if (v == hold_idx)
        for (int i = 1; i < hold; i++) begin
          i_CfgWrEn = i == 2; i_CfgAddr = a_cos_pitch; i_CfgData = 16'hFFFF;
          step();
        end
      i_CfgWrEn = 1'b0; i_PixelReady = 1'b1;
      step();
      i_PixelReady = 1'b0;
    end
  endtask
  localparam logic [255:0] bus3 =
    256'h4E40_0000_C799_0000_0000_0000_0000_0000_0000_0000_0000_0000_4700_0000_0000_0000;
  int e0, d0, r0;
  initial begin
    i_Rst_n = 1'b0; i_CfgWrEn = 1'b0; i_CfgAddr = '0; i_CfgData = '0; i_Start = 1'b0;
    i_VertexCount = '0; i_VertexValid = 1'b0; i_PixelReady = 1'b0;
    i_VertexX = '0; i_VertexY = '0; i_VertexZ = '0;
    repeat (3) step();
    chk("rst_flags", 256'({o_Busy, o_Done, o_DpValid, o_PixelValid, o_CfgErr, o_VertexReady}), 256'(0));
    chk("rst_bus", o_ParamBus, 256'(0));
    i_Rst_n = 1'b1;
    cfg(a_transl_x, 16'hC799);
    cfg(a_transl_z, 16'h4E40);
    cfg(a_cam_dc, 16'h4700);
    chk("p13", 256'(o_ParamBus[223:208]), 256'(16'hC799));
    chk("p15", 256'(o_ParamBus[255:240]), 256'(16'h4E40));
    chk("p3", 256'(o_ParamBus[63:48]), 256'(16'h4700));
    cfg(5'd20, 16'hBEEF);
    chk("err_addr20", 256'(o_CfgErr), 256'(1));
    step();
    chk("err_once", 256'(o_CfgErr), 256'(0));
    chk("bus_after_bad", o_ParamBus, bus3);
    i_Start = 1'b1; i_VertexCount = 16'd0;
    step();
    i_Start = 1'b0;
    chk("n0_done", 256'({o_Done, o_Busy}), 256'(2'b10));
    step();
    chk("n0_after", 256'({o_Done, o_Busy}), 256'(2'b00));
    batch(1, -1, 1, 16'hCD40, 16'h4780, 16'hC500);
    repeat (2) step();
    chk("n1_dpv_lat", 256'(ev_dpv - ev_acc), 256'(1));
    chk("n1_pv_lat", 256'(ev_pv - ev_acc), 256'(5));
    chk("n1_pixel", 256'({o_PixelX, o_PixelY}), 256'(32'h1234_5678));
    chk("n1_vertex", 256'({o_DpVertexX, o_DpVertexY, o_DpVertexZ}), 256'(48'hCD40_4780_C500));
    chk("n1_done_lat", 256'(ev_done - ev_hs), 256'(1));
    e0 = n_pix; d0 = n_done; r0 = n_err;
    batch(3, 1, 7, 16'h3C00, 16'h4000, 16'h4200);
    repeat (2) step();
    chk("n3_outputs", 256'(n_pix - e0), 256'(3));
    chk("n3_done", 256'(n_done - d0), 256'(1));
    chk("n3_err", 256'(n_err - r0), 256'(1));
    chk("n3_bus", o_ParamBus, bus3);
    i_Start = 1'b1; i_VertexCount = 16'd2;
    step();
    i_Start = 1'b0;
    i_VertexX = 16'h1111; i_VertexY = 16'h2222; i_VertexZ = 16'h3333; i_VertexValid = 1'b1;
    await(1'b0, "rst_vready_timeout");
    step();
    i_VertexValid = 1'b0;
    step();
    chk("wait_busy", 256'({o_Busy, o_VertexReady, o_PixelValid}), 256'(3'b100));
    i_Rst_n = 1'b0;
    step();
    chk("rst_mid_flags", 256'({o_Busy, o_Done, o_DpValid, o_PixelValid, o_CfgErr, o_VertexReady}), 256'(0));
    chk("rst_mid_data", 256'({o_DpVertexX, o_DpVertexY, o_DpVertexZ, o_PixelX, o_PixelY}), 256'(0));
    chk("rst_mid_bus", o_ParamBus, 256'(0));
    i_Rst_n = 1'b1;
    d0 = n_done;
    repeat (8) step();
    chk("rst_no_done", 256'(n_done - d0), 256'(0));
    i_CfgWrEn = 1'b1; i_CfgAddr = a_cam_ver_x; i_CfgData = 16'h3C00;
    batch(1, -1, 1, 16'h0001, 16'h0002, 16'h0003);
    repeat (2) step();
    chk("cfg_with_start", 256'(o_ParamBus[15:0]), 256'(16'h3C00));
    chk("post_rst_done", 256'(n_done - d0), 256'(1));
    chk("post_rst_pixel", 256'({o_PixelX, o_PixelY}), 256'(32'h1234_5678));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
